// File: rtl/dac_playback_ctrl_pkg.sv
// Shared definitions for the DAC playback sequencer: playback states and
// AD9767 sample format constants.
package dac_playback_ctrl_pkg;

    localparam int AD9767_DATA_W = 14;
    localparam logic [AD9767_DATA_W-1:0] MIDSCALE_CODE = 14'd8192;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_RUN    = 2'd2,
        ST_FINISH = 2'd3
    } play_state_e;

endpackage

// File: rtl/dac_playback_ctrl_sample_fifo.sv
// Synchronous show-ahead sample FIFO with flush and occupancy output.
// Writes when full and reads when empty are ignored internally.
module sample_fifo #(
    parameter int FIFO_AW = 4,
    parameter int DATA_W  = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [FIFO_AW:0]  level
);

    localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW+1)'(2**FIFO_AW);

    logic [DATA_W-1:0]  mem_r [2**FIFO_AW];
    logic [FIFO_AW-1:0] wr_ptr_r;
    logic [FIFO_AW-1:0] rd_ptr_r;
    logic [FIFO_AW:0]   level_r;
    logic               push_s;
    logic               pop_s;

    assign full    = (level_r == DEPTH);
    assign empty   = (level_r == '0);
    assign level   = level_r;
    assign rd_data = mem_r[rd_ptr_r];
    assign push_s  = push && !full && !flush;
    assign pop_s   = pop && !empty && !flush;

    // Pointer and occupancy bookkeeping; flush discards everything held.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + FIFO_AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + FIFO_AW'(1);
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + (FIFO_AW+1)'(1);
                2'b01:   level_r <= level_r - (FIFO_AW+1)'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Sample storage, no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r] <= wr_data;
    end

endmodule

// File: rtl/dac_playback_ctrl.sv
// Buffers producer samples and releases one per programmable rate tick to
// the AD9767 interface, with burst/continuous play, abort and underrun flag.
module dac_playback_ctrl import dac_playback_ctrl_pkg::*; #(
    parameter int                DATA_W      = AD9767_DATA_W,
    parameter int                DIV_W       = 16,
    parameter int                CNT_W       = 16,
    parameter int                FIFO_AW     = 4,
    parameter int                PRIME_LEVEL = 4,
    parameter logic [DATA_W-1:0] IDLE_CODE   = MIDSCALE_CODE
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic [DIV_W-1:0]   i_rate_div,
    input  logic [CNT_W-1:0]   i_burst_len,
    input  logic               i_smp_valid,
    input  logic [DATA_W-1:0]  i_smp_data,
    output logic               o_smp_ready,
    output logic [DATA_W-1:0]  o_dac_data,
    output logic               o_dac_strobe,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_underrun,
    output logic [FIFO_AW:0]   o_fifo_level
);

    play_state_e       state_r, state_s;
    logic [DIV_W-1:0]  div_r, div_cnt_r;
    logic [CNT_W-1:0]  burst_r, played_r;
    logic [DATA_W-1:0] dac_data_r;
    logic              strobe_r, done_r, underrun_r;

    logic              push_s, pop_s, flush_s, launch_s, tick_s, prime_ok_s;
    logic [CNT_W-1:0]  target_s;
    logic [DATA_W-1:0] fifo_rd_s;
    logic              full_s, empty_s;
    logic [FIFO_AW:0]  level_s;

    sample_fifo #(.FIFO_AW(FIFO_AW), .DATA_W(DATA_W)) u_fifo (
        .clk     (i_clk),
        .rst     (i_rst),
        .flush   (flush_s),
        .push    (push_s),
        .wr_data (i_smp_data),
        .pop     (pop_s),
        .rd_data (fifo_rd_s),
        .full    (full_s),
        .empty   (empty_s),
        .level   (level_s)
    );

    // A short burst only needs as many samples as it will play.
    assign target_s   = (burst_r != '0 && burst_r < CNT_W'(PRIME_LEVEL)) ? burst_r : CNT_W'(PRIME_LEVEL);
    assign prime_ok_s = (CNT_W'(level_s) >= target_s);
    assign tick_s     = (state_r == ST_RUN) && (div_cnt_r == '0);
    assign push_s     = i_smp_valid && !full_s && !i_stop;

    // Next-state and FIFO control; stop overrides every other request.
    always_comb begin
        state_s  = state_r;
        pop_s    = 1'b0;
        flush_s  = 1'b0;
        launch_s = 1'b0;
        if (i_stop) begin
            flush_s = 1'b1;
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_start) begin
                        launch_s = 1'b1;
                        state_s  = ST_PRIME;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_PRIME: begin
                    if (prime_ok_s) state_s = ST_RUN;
                    else            state_s = ST_PRIME;
                end
                ST_RUN: begin
                    if (tick_s && !empty_s) begin
                        pop_s = 1'b1;
                        if (burst_r != '0 && (played_r + CNT_W'(1)) == burst_r) state_s = ST_FINISH;
                        else                                                    state_s = ST_RUN;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_FINISH: state_s = ST_IDLE;
                default:   state_s = ST_IDLE;
            endcase
        end
    end

    // State, rate divider, play counter and registered DAC-side outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= ST_IDLE;
            div_r      <= '0;
            div_cnt_r  <= '0;
            burst_r    <= '0;
            played_r   <= '0;
            dac_data_r <= IDLE_CODE;
            strobe_r   <= 1'b0;
            done_r     <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            strobe_r <= 1'b0;
            done_r   <= 1'b0;
            if (launch_s) begin
                div_r      <= i_rate_div;
                burst_r    <= i_burst_len;
                played_r   <= '0;
                underrun_r <= 1'b0;
            end
            if (state_r == ST_PRIME)     div_cnt_r <= '0;
            else if (state_r == ST_RUN)  div_cnt_r <= tick_s ? div_r : div_cnt_r - DIV_W'(1);
            if (pop_s) begin
                dac_data_r <= fifo_rd_s;
                strobe_r   <= 1'b1;
                played_r   <= played_r + CNT_W'(1);
            end else if (i_stop && state_r != ST_IDLE) begin
                dac_data_r <= IDLE_CODE;
            end else if (state_r == ST_FINISH) begin
                dac_data_r <= IDLE_CODE;
                done_r     <= 1'b1;
            end
            if (tick_s && empty_s && !i_stop) underrun_r <= 1'b1;
        end
    end

    assign o_smp_ready  = !full_s;
    assign o_dac_data   = dac_data_r;
    assign o_dac_strobe = strobe_r;
    assign o_busy       = (state_r != ST_IDLE);
    assign o_done       = done_r;
    assign o_underrun   = underrun_r;
    assign o_fifo_level = level_s;

endmodule

// File: tb/tb_dac_playback_ctrl.sv
// Self-checking bench for dac_playback_ctrl: directed vector table, corner
// sequences and randomized traffic against a queue-based reference model.
module tb_dac_playback_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0, i_start = 1'b0, i_stop = 1'b0, i_smp_valid = 1'b0;
    logic [15:0] i_rate_div = 16'd0, i_burst_len = 16'd0;
    logic [13:0] i_smp_data = 14'd0;
    logic        o_smp_ready, o_dac_strobe, o_busy, o_done, o_underrun;
    logic [13:0] o_dac_data;
    logic [4:0]  o_fifo_level;

    dac_playback_ctrl dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_stop(i_stop),
        .i_rate_div(i_rate_div), .i_burst_len(i_burst_len),
        .i_smp_valid(i_smp_valid), .i_smp_data(i_smp_data),
        .o_smp_ready(o_smp_ready), .o_dac_data(o_dac_data), .o_dac_strobe(o_dac_strobe),
        .o_busy(o_busy), .o_done(o_done), .o_underrun(o_underrun), .o_fifo_level(o_fifo_level)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: playback phase, sample queue and expected outputs.
    int q[$];
    int m_phase = 0;  // 0 idle, 1 priming, 2 playing, 3 finishing
    int m_div = 0, m_burst = 0, m_cnt = 0, m_wait = 0;
    int m_data = 8192;
    bit m_strobe = 0, m_done = 0, m_underrun = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        int pre = q.size();
        bit take = i_smp_valid && (pre < 16);
        int need;
        m_strobe = 0;
        m_done   = 0;
        if (i_rst) begin
            q.delete();
            m_phase = 0; m_data = 8192; m_underrun = 0;
            return;
        end
        if (i_stop) begin
            q.delete();
            if (m_phase != 0) begin
                m_phase = 0;
                m_data  = 8192;
            end
            return;
        end
        case (m_phase)
            0: if (i_start) begin
                m_div = int'(i_rate_div); m_burst = int'(i_burst_len);
                m_cnt = 0; m_underrun = 0; m_phase = 1;
            end
            1: begin
                need = (m_burst != 0 && m_burst < 4) ? m_burst : 4;
                if (pre >= need) begin
                    m_phase = 2;
                    m_wait  = 0;
                end
            end
            2: if (m_wait == 0) begin
                m_wait = m_div;
                if (pre > 0) begin
                    m_data   = q.pop_front();
                    m_strobe = 1;
                    m_cnt    = (m_cnt + 1) % 65536;
                    if (m_burst != 0 && m_cnt == m_burst) m_phase = 3;
                end else begin
                    m_underrun = 1;
                end
            end else begin
                m_wait--;
            end
            default: begin
                m_data = 8192; m_done = 1; m_phase = 0;
            end
        endcase
        if (take) q.push_back(int'(i_smp_data));
    endtask

    // One clock: drive inputs, advance DUT and model together, compare.
    task automatic step(input bit rst, input bit st, input bit sp, input bit v,
                        input int d, input int div, input int bl);
        i_rst = rst; i_start = st; i_stop = sp; i_smp_valid = v;
        i_smp_data = 14'(d); i_rate_div = 16'(div); i_burst_len = 16'(bl);
        @(posedge i_clk);
        model_step();
        #1;
        cyc++;
        chk("smp_ready",  int'(o_smp_ready),  (q.size() < 16) ? 1 : 0);
        chk("dac_data",   int'(o_dac_data),   m_data);
        chk("dac_strobe", int'(o_dac_strobe), int'(m_strobe));
        chk("busy",       int'(o_busy),       (m_phase != 0) ? 1 : 0);
        chk("done",       int'(o_done),       int'(m_done));
        chk("underrun",   int'(o_underrun),   int'(m_underrun));
        chk("fifo_level", int'(o_fifo_level), q.size());
    endtask

    task automatic idle_cyc();
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic preload(input int n, input int base);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1, base + i, 0, 0);
    endtask

    typedef struct {
        bit rst, start, valid;
        int data, div, burst;
        bit exp_strobe, exp_done, exp_busy;
        int exp_data, exp_level;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit st, bit v, int d, int div, int bl,
                                bit es, int ed, bit edn, bit eb, int el);
        vec_t t;
        t.rst = rst; t.start = st; t.valid = v; t.data = d; t.div = div; t.burst = bl;
        t.exp_strobe = es; t.exp_data = ed; t.exp_done = edn; t.exp_busy = eb; t.exp_level = el;
        return t;
    endfunction

    int strobes, dones;

    initial begin
        // Burst of four at div=3: strobes four clocks apart, done one cycle later.
        vecs.push_back(mk(1, 0, 0,   0, 0, 0, 0, 8192, 0, 0, 0));
        for (int i = 1; i <= 4; i++) vecs.push_back(mk(0, 0, 1, 100 * i, 0, 0, 0, 8192, 0, 0, i));
        vecs.push_back(mk(0, 1, 0, 0, 3, 4, 0, 8192, 0, 1, 4));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8192, 0, 1, 4));
        for (int s = 1; s <= 4; s++) begin
            vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 100 * s, 0, 1, 4 - s));
            if (s < 4)
                for (int k = 0; k < 3; k++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 100 * s, 0, 1, 4 - s));
        end
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8192, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8192, 0, 0, 0));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].start, 1'b0, vecs[i].valid, vecs[i].data, vecs[i].div, vecs[i].burst);
            chk("tbl_strobe", int'(o_dac_strobe), int'(vecs[i].exp_strobe));
            chk("tbl_data",   int'(o_dac_data),   vecs[i].exp_data);
            chk("tbl_done",   int'(o_done),       int'(vecs[i].exp_done));
            chk("tbl_busy",   int'(o_busy),       int'(vecs[i].exp_busy));
            chk("tbl_level",  int'(o_fifo_level), vecs[i].exp_level);
        end

        // Continuous full-rate play with a slow producer must underrun.
        preload(4, 500);
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        idle_cyc();
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, (i % 3) == 0, 600 + i, 0, 0);
        chk("underrun_set", int'(o_underrun), 1);
        chk("underrun_busy", int'(o_busy), 1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
        chk("stop_idle_level", int'(o_fifo_level), 0);

        // Fill to capacity, then one push refused at full.
        preload(16, 1000);
        chk("full_ready", int'(o_smp_ready), 0);
        chk("full_level", int'(o_fifo_level), 16);
        step(1'b0, 1'b0, 1'b0, 1'b1, 2000, 0, 0);
        chk("push_at_full", int'(o_fifo_level), 16);
        step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0);

        // Push and pop together at level 8 keep the level.
        preload(8, 3000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        idle_cyc();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 3100 + i, 0, 0);
            chk("push_pop_level", int'(o_fifo_level), 8);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0);

        // Abort while playing with ten buffered.
        preload(10, 4000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, 5, 0);
        idle_cyc();
        step(1'b0, 1'b0, 1'b1, 1'b1, 4500, 0, 0);
        chk("abort_busy",  int'(o_busy), 0);
        chk("abort_level", int'(o_fifo_level), 0);
        chk("abort_data",  int'(o_dac_data), 8192);
        chk("abort_done",  int'(o_done), 0);

        // Burst shorter than the prime level.
        preload(2, 11);
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, 1, 2);
        strobes = 0; dones = 0;
        for (int i = 0; i < 7; i++) begin
            idle_cyc();
            strobes += int'(o_dac_strobe);
            dones   += int'(o_done);
        end
        chk("short_burst_strobes", strobes, 2);
        chk("short_burst_done", dones, 1);
        chk("short_burst_idle_code", int'(o_dac_data), 8192);

        // Start and stop together in idle: stop wins and flushes.
        preload(3, 50);
        step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0);
        chk("start_stop_busy",  int'(o_busy), 0);
        chk("start_stop_level", int'(o_fifo_level), 0);

        // Reset in the middle of a burst.
        preload(4, 70);
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 4);
        idle_cyc();
        idle_cyc();
        idle_cyc();
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        chk("rst_data",   int'(o_dac_data), 8192);
        chk("rst_busy",   int'(o_busy), 0);
        chk("rst_done",   int'(o_done), 0);
        chk("rst_level",  int'(o_fifo_level), 0);
        chk("rst_ready",  int'(o_smp_ready), 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 399) == 0, $urandom_range(0, 14) == 0,
                 $urandom_range(0, 79) == 0, $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 16383)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 6)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_playback_ctrl.md
Name: dac_playback_ctrl

Overview:
Sequences sample playback into the AD9767 DAC interface: buffers samples from an upstream producer in a small FIFO and releases one sample per programmable rate tick. Supports finite bursts or continuous play, start/stop control, underrun detection and return to a safe idle code. Sits between any sample source (UART loader, waveform generator, ADC loopback) and the `ad9767if` data input.

Parameters:
DATA_W, 14, DAC sample width
DIV_W, 16, rate divider width
CNT_W, 16, burst counter width
FIFO_AW, 4, FIFO address bits (depth 2**FIFO_AW = 16)
PRIME_LEVEL, 4, FIFO fill required before first output
IDLE_CODE, 14'd8192, midscale code driven when not playing

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous, active-high reset
i_start  in  1  one-cycle start request
i_stop  in  1  one-cycle abort request
i_rate_div  in  DIV_W  sample period minus 1, in clocks; latched on start
i_burst_len  in  CNT_W  samples to play; 0 = continuous; latched on start
i_smp_valid  in  1  producer sample valid
i_smp_data  in  DATA_W  producer sample
o_smp_ready  out  1  FIFO can accept (= !full)
o_dac_data  out  DATA_W  registered sample to DAC interface
o_dac_strobe  out  1  one-cycle pulse: o_dac_data updated with a new sample
o_busy  out  1  state != IDLE
o_done  out  1  one-cycle pulse at burst completion
o_underrun  out  1  sticky; set when a tick finds the FIFO empty in RUN
o_fifo_level  out  FIFO_AW+1  current FIFO occupancy

Behaviour:
- Reset (synchronous, active-high, i_rst):
  - FIFO emptied; state IDLE.
  - o_dac_data = IDLE_CODE; all other outputs 0.
  - o_smp_ready = 1 in the cycle after reset.
- FIFO:
  - Push when i_smp_valid && o_smp_ready, in any state, including IDLE preload.
  - Push and pop in the same cycle are both honoured; level is unchanged.
  - No push when full; the producer holds its data.
- States:
  - IDLE: on i_start (with i_stop low), latch div and burst_len, clear o_underrun, go to PRIME.
  - PRIME: wait until level >= target. Target = min(PRIME_LEVEL, burst_len) when burst_len != 0, else PRIME_LEVEL. Then go to RUN and load the divider counter with 0.
  - RUN:
    - Divider counts down; tick when counter == 0, then reload with the latched div. Sample rate = f_clk / (div + 1).
    - First tick occurs in the first RUN cycle.
    - Tick with FIFO non-empty: pop; next cycle o_dac_data = sample and o_dac_strobe = 1; played count increments.
    - Tick with FIFO empty: o_underrun <= 1; o_dac_data holds its last value; no strobe; count unchanged; state stays RUN.
    - When burst_len != 0 and the count reaches burst_len (after that sample's strobe), go to FINISH.
  - FINISH (1 cycle): o_dac_data <= IDLE_CODE, o_done = 1, go to IDLE. Samples left in the FIFO are retained.
- i_stop:
  - In any non-IDLE state, the next cycle forces IDLE, flushes the FIFO, drives o_dac_data = IDLE_CODE and does not pulse o_done.
  - A push in the same cycle as a stop is dropped.
  - In IDLE, i_stop flushes the FIFO.
  - i_stop has priority over i_start.
- i_start while busy: ignored. i_rate_div / i_burst_len changes while busy: no effect.
- Divider wrap: div = 0 gives a tick every cycle (full rate). Count is CNT_W bits; in continuous mode it wraps and is not compared.
- i_rst asserted mid-burst: same as reset; no o_done.

Decomposition:
- Shared header/package: state encodings (IDLE, PRIME, RUN, FINISH), default IDLE_CODE midscale constant, DATA_W for the AD9767.
- One sub-module: sample_fifo, a synchronous FIFO with parameters FIFO_AW and DATA_W, push/pop, full/empty, and a level output.

Test Plan:
- Preload 4 samples 100, 200, 300, 400 in IDLE; start with div = 3, burst = 4 -> strobes spaced exactly 4 clocks, data 100, 200, 300, 400 in order; o_done one cycle after the last strobe; o_dac_data returns to 8192.
- Continuous mode, div = 0, producer sends 1 sample every 3 clocks -> o_underrun sets on the first empty tick; o_dac_data holds its last value; no strobe on empty ticks.
- Fill the FIFO to 16 -> o_smp_ready = 0; a push attempted at full is not accepted; a simultaneous push and pop at level 8 leaves level 8.
- i_stop during RUN with 10 samples buffered -> next cycle: IDLE, level 0, o_dac_data = 8192, no o_done.
- burst = 2 with PRIME_LEVEL = 4, only 2 samples supplied -> leaves PRIME at level 2, plays 2 samples, done.
- i_start and i_stop asserted in the same cycle in IDLE -> stays IDLE, FIFO flushed. i_rst asserted mid-burst -> all outputs at reset values the next cycle.
